// File: rtl/w_side_frontend.sv
// Write-side front end of the async FIFO: skid-buffered producer handshake, RAM write port and r_ptr_g synchroniser.
// Define WFE_LEVEL_EN to build the write-side fill level (w_level) and almost-full flag (w_afull).
module w_side_frontend #(
   parameter int DATA_W       = 8,
   parameter int ADDR_W       = 6,
   parameter int SYNC_STAGES  = 2,
   parameter int AFULL_THRESH = 56
) (
   input  logic              w_clk,
   input  logic              w_rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic [ADDR_W:0]   r_ptr_g,
   output logic [ADDR_W:0]   r_ptr_g_sync,
   input  logic [ADDR_W:0]   w_ptr_g,
   input  logic              w_full,
   input  logic [ADDR_W-1:0] w_addr,
   output logic              w_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [ADDR_W:0]   w_level,
   output logic              w_afull
);
   localparam int PW = ADDR_W + 1;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t                           state, state_nx;
   logic [DATA_W-1:0]                m_q, k_q;
   logic [SYNC_STAGES-1:0][PW-1:0]   sync_q;
   logic                             accept;

   assign accept       = s_valid & s_ready;
   assign w_en         = (state != EMPTY) & ~w_full;
   assign mem_we       = w_en;
   assign mem_waddr    = w_addr;
   assign mem_wdata    = m_q;
   assign r_ptr_g_sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_nx = state;
      case (state)
         EMPTY:   if (accept) state_nx = ONE;
         ONE:     if (accept && !w_en) state_nx = TWO;
                  else if (!accept && w_en) state_nx = EMPTY;
         TWO:     if (w_en) state_nx = ONE;
         default: state_nx = EMPTY;
      endcase
   end

   // K only ever catches a word while M is occupied and stalled, so order is M then K.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         state   <= EMPTY;
         s_ready <= 1'b0;
         m_q     <= '0;
         k_q     <= '0;
      end else begin
         state   <= state_nx;
         s_ready <= (state_nx != TWO);
         case (state)
            EMPTY: if (accept) m_q <= s_data;
            ONE: begin
               if (accept && w_en)  m_q <= s_data;
               if (accept && !w_en) k_q <= s_data;
            end
            TWO:     if (w_en) m_q <= k_q;
            default: ;
         endcase
      end
   end

   // Plain flop chain: nothing may sit between stages of a crossing.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], r_ptr_g};
   end

`ifdef WFE_LEVEL_EN
   function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [PW-1:0] lvl_nx;

   // Uses the synchronised read pointer, so the level over-reports until reads cross over.
   assign lvl_nx = g2b(w_ptr_g) - g2b(r_ptr_g_sync);

   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         w_level <= '0;
         w_afull <= 1'b0;
      end else begin
         w_level <= lvl_nx;
         w_afull <= (lvl_nx >= PW'(AFULL_THRESH));
      end
   end
`else
   logic unused_w_ptr_g;

   assign unused_w_ptr_g = ^w_ptr_g;
   assign w_level        = '0;
   assign w_afull        = 1'b0;
`endif

endmodule

// File: tb/tb_w_side_frontend.sv
// Bench for w_side_frontend: the bench plays producer, reader and pointer controller around the DUT.
module tb_w_side_frontend;
   localparam int DW = 8, AW = 6, PW = 7, SS = 2, TH = 56;

   logic          w_clk = 1'b0, w_rst = 1'b1;
   logic          s_valid, s_ready, w_full, w_en, mem_we, w_afull;
   logic [DW-1:0] s_data, mem_wdata;
   logic [PW-1:0] r_ptr_g, r_ptr_g_sync, w_ptr_g, w_level;
   logic [AW-1:0] w_addr, mem_waddr;

   w_side_frontend #(.DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(SS), .AFULL_THRESH(TH)) dut (
      .w_clk(w_clk), .w_rst(w_rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .r_ptr_g(r_ptr_g), .r_ptr_g_sync(r_ptr_g_sync), .w_ptr_g(w_ptr_g), .w_full(w_full),
      .w_addr(w_addr), .w_en(w_en), .mem_we(mem_we), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .w_level(w_level), .w_afull(w_afull));

   always #5 w_clk = ~w_clk;

   int total = 0, bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [PW-1:0] gray(input int b);
      logic [PW-1:0] v;
      v = b[PW-1:0];
      return v ^ (v >> 1);
   endfunction

   // Pointer controller + reader history model.
   logic [PW-1:0] wptr, rptr;
   logic [PW-1:0] rh [0:SS];
   logic          tog, post_edge;
   logic          noise_en, hold_full;
   int            lvl_exp;

   assign w_addr  = wptr[AW-1:0];
   assign w_ptr_g = wptr ^ (wptr >> 1);

   always @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         wptr <= '0; w_full <= 1'b0; tog <= 1'b0; post_edge <= 1'b0; lvl_exp <= 0;
         for (int i = 0; i <= SS; i++) rh[i] <= '0;
      end else begin
         wptr   <= wptr + {{(PW-1){1'b0}}, w_en};
         w_full <= (PW'(wptr + {{(PW-1){1'b0}}, w_en} - rh[SS-1]) == 7'd64)
                   | (noise_en & tog) | hold_full;
         tog       <= ~tog;
         post_edge <= 1'b1;
         rh[0]     <= rptr;
         for (int i = 1; i <= SS; i++) rh[i] <= rh[i-1];
         lvl_exp   <= int'(PW'(wptr - rh[SS-1]));
      end
   end

   // Scoreboard: accepted words in issue order.
   logic [DW-1:0] q [$];
   int            wcnt = 0;

   always @(posedge w_clk)
      if (!w_rst && s_valid && s_ready) q.push_back(s_data);

   always @(negedge w_clk) begin
      if (w_rst) begin
         q.delete();
         wcnt = 0;
      end else if (post_edge) begin
         chk("mem_we", mem_we, int'(q.size() > 0 && !w_full));
         chk("w_en", w_en, int'(q.size() > 0 && !w_full));
         chk("s_ready", s_ready, int'(q.size() < 2));
         chk("sync", r_ptr_g_sync, gray(int'(rh[SS-1])));
         if (mem_we) begin
            if (q.size() == 0) chk("underflow", 1, 0);
            else chk("wdata", mem_wdata, q.pop_front());
            chk("waddr", mem_waddr, wcnt % 64);
            wcnt++;
         end
`ifdef WFE_LEVEL_EN
         chk("level", w_level, lvl_exp);
         chk("afull", w_afull, int'(lvl_exp >= TH));
`else
         chk("level", w_level, 0);
         chk("afull", w_afull, 0);
`endif
      end
   end

   int rd_cnt;

   task automatic set_rd(input int n);
      rd_cnt  = n;
      rptr    = n[PW-1:0];
      r_ptr_g = gray(n);
   endtask

   // Called just after a negedge; returns just after the negedge following the accept edge.
   task automatic send(input logic [DW-1:0] d);
      int n = 0;
      s_valid = 1'b1;
      s_data  = d;
      while (!s_ready && n < 300) begin
         @(negedge w_clk);
         n++;
      end
      if (n >= 300) begin
         chk("send_timeout", 0, 1);
         s_valid = 1'b0;
      end
      @(negedge w_clk);
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) @(negedge w_clk);
   endtask

   task automatic do_reset();
      #2;
      w_rst = 1'b1; s_valid = 1'b0; hold_full = 1'b0; noise_en = 1'b0;
      set_rd(0);
      #1;
      chk("rst_s_ready", s_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_sync", r_ptr_g_sync, 0);
      chk("rst_level", w_level, 0);
      chk("rst_afull", w_afull, 0);
      repeat (3) @(negedge w_clk);
      w_rst = 1'b0;
      @(negedge w_clk);
      chk("rel_s_ready", s_ready, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n, c0;
      bit  done;
      s_valid = 1'b0; s_data = '0; hold_full = 1'b0; noise_en = 1'b0;
      set_rd(0);
      @(negedge w_clk);
      do_reset();

      // single word, one-cycle latency to the RAM port
      send(8'h11);
      chk("t1_we", mem_we, 1);
      chk("t1_data", mem_wdata, 'h11);
      chk("t1_addr", mem_waddr, 0);
      idle(2);

      // fill to full with no reads, two words held, then release
      do_reset();
      for (int i = 0; i < 66; i++) send(DW'(i));
      idle(4);
      #1;
      chk("t2_writes", wcnt, 64);
      chk("t2_s_ready", s_ready, 0);
      chk("t2_w_en", w_en, 0);
      chk("t2_held", q.size(), 2);
      @(negedge w_clk);
      set_rd(2);
      idle(12);
      #1;
      chk("t2_drained", wcnt, 66);
      chk("t2_empty", q.size(), 0);

      // w_full toggling every cycle during a 10-word burst
      do_reset();
      noise_en = 1'b1;
      c0 = wcnt;
      for (int i = 0; i < 10; i++) send(DW'(8'hA0 + i));
      idle(30);
      #1;
      chk("t3_writes", wcnt - c0, 10);
      @(negedge w_clk);
      noise_en = 1'b0;

      // synchroniser latency
      do_reset();
      set_rd(1);
      n = 0;
      while (r_ptr_g_sync == '0 && n < 10) begin
         @(posedge w_clk); #1; n++;
      end
      chk("t4_sync_lat", n, SS);
      chk("t4_sync_val", r_ptr_g_sync, 1);
      @(negedge w_clk);

`ifdef WFE_LEVEL_EN
      do_reset();
      for (int i = 0; i < 56; i++) send(DW'(i));
      idle(6);
      #1;
      chk("t5_level", w_level, 56);
      chk("t5_afull", w_afull, 1);
      @(negedge w_clk);
      set_rd(1);
      n = 0;
      while (w_afull && n < 10) begin
         @(posedge w_clk); #1; n++;
      end
      chk("t5_afull_lat", n, SS + 1);
      @(negedge w_clk);
`endif

      // reset with both slots occupied
      do_reset();
      hold_full = 1'b1;
      send(8'h5A);
      send(8'hA5);
      idle(1);
      #1;
      chk("t6_s_ready", s_ready, 0);
      chk("t6_mem_we", mem_we, 0);
      chk("t6_held", q.size(), 2);
      @(negedge w_clk);
      do_reset();
      idle(4);
      #1;
      chk("t6_no_write", wcnt, 0);
      chk("t6_level", w_level, 0);
      @(negedge w_clk);

      // randomized traffic with a concurrent reader
      do_reset();
      done = 0;
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               if ($urandom % 4 == 0) idle($urandom_range(1, 3));
               send(DW'($urandom));
            end
            idle(1);
            done = 1;
         end
         begin
            int g = 0;
            while (!(done && q.size() == 0) && g < 5000) begin
               @(negedge w_clk);
               g++;
               if ($urandom % 3 == 0 && rd_cnt < wcnt) set_rd(rd_cnt + 1);
            end
            if (g >= 5000) chk("rand_timeout", 0, 1);
         end
      join
      idle(2);
      #1;
      chk("rand_writes", wcnt, 200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
